// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the MAC transmit scheduler.
package tx_sched_pkg;

  localparam int unsigned TX_W           = 32;
  localparam int unsigned MOD_W          = 2;
  localparam int unsigned DEF_IFG_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT    = 2048;
  localparam int unsigned WD_W           = 12;
  localparam int unsigned GAP_W          = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StXfer,
    StAbort,
    StGap
  } state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_sched_if.sv
// Single 32-bit MAC transmit bus with ready back-pressure and underflow flag.
interface tx_sched_if;
  import tx_sched_pkg::*;

  logic [TX_W-1:0]  tx_data;
  logic [MOD_W-1:0] tx_mod;
  logic             tx_sop;
  logic             tx_eop;
  logic             tx_wren;
  logic             tx_err;
  logic             tx_rdy;
  logic             tx_uflow;

  modport master (
    output tx_data, tx_mod, tx_sop, tx_eop, tx_wren, tx_err,
    input  tx_rdy, tx_uflow
  );

  modport slave (
    input  tx_data, tx_mod, tx_sop, tx_eop, tx_wren, tx_err,
    output tx_rdy, tx_uflow
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request strictly above last, else lowest request.
module rr_pick import tx_sched_pkg::*; #(
  parameter int unsigned N    = 3,
  parameter int unsigned SelW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SelW-1:0] last,
  output logic [SelW-1:0] sel,
  output logic            valid
);

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    // Descending scans leave the lowest match; the second scan overrides with the wrap-free pick.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel   = SelW'(i);
        valid = 1'b1;
      end
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i] && (SelW'(i) > last)) begin
        sel = SelW'(i);
      end
    end
  end

endmodule

// File: rtl/tx_sched.sv
// Round-robin scheduler sharing one MAC transmit port among N_REQ frame generators,
// with inter-frame gap, frame watchdog and a saturating error counter.
module tx_sched import tx_sched_pkg::*; #(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned IFG_CYCLES = DEF_IFG_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       start,
  output logic [N_REQ-1:0]       grant,
  input  logic [TX_W*N_REQ-1:0]  s_tx_data,
  input  logic [MOD_W*N_REQ-1:0] s_tx_mod,
  input  logic [N_REQ-1:0]       s_tx_sop,
  input  logic [N_REQ-1:0]       s_tx_eop,
  input  logic [N_REQ-1:0]       s_tx_wren,
  input  logic [N_REQ-1:0]       s_tx_err,
  output logic [N_REQ-1:0]       s_tx_rdy,
  tx_sched_if.master             mac,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam int unsigned SelW = sel_width(N_REQ);
  localparam logic [WD_W-1:0]  WdLast  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GapLast = GAP_W'(IFG_CYCLES - 1);

  state_e            state_q;
  logic [SelW-1:0]   sel_q, last_q, pick_sel;
  logic              pick_valid;
  logic [N_REQ-1:0]  start_q, grant_q, pick_oh;
  logic [WD_W-1:0]   wd_q;
  logic [GAP_W-1:0]  gap_q;
  logic [7:0]        err_cnt_q;

  logic [TX_W-1:0]   g_data;
  logic [MOD_W-1:0]  g_mod;
  logic              g_sop, g_eop, g_wren, g_err;
  logic              frame_end, err_inc;

  rr_pick #(
    .N    (N_REQ),
    .SelW (SelW)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  assign pick_oh = N_REQ'(1) << pick_sel;

  always_comb begin
    g_data = '0;
    g_mod  = '0;
    g_sop  = 1'b0;
    g_eop  = 1'b0;
    g_wren = 1'b0;
    g_err  = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (sel_q == SelW'(i)) begin
        g_data = s_tx_data[i*TX_W +: TX_W];
        g_mod  = s_tx_mod[i*MOD_W +: MOD_W];
        g_sop  = s_tx_sop[i];
        g_eop  = s_tx_eop[i];
        g_wren = s_tx_wren[i];
        g_err  = s_tx_err[i];
      end
    end
  end

  always_comb begin
    mac.tx_data = '0;
    mac.tx_mod  = '0;
    mac.tx_sop  = 1'b0;
    mac.tx_eop  = 1'b0;
    mac.tx_wren = 1'b0;
    mac.tx_err  = 1'b0;
    s_tx_rdy    = '0;
    unique case (state_q)
      StXfer: begin
        mac.tx_data = g_data;
        mac.tx_mod  = g_mod;
        mac.tx_sop  = g_sop;
        mac.tx_eop  = g_eop;
        mac.tx_wren = g_wren;
        mac.tx_err  = g_err;
        s_tx_rdy    = N_REQ'(mac.tx_rdy) << sel_q;
      end
      // Forced error EOP so the MAC closes out the hung frame.
      StAbort: begin
        mac.tx_wren = 1'b1;
        mac.tx_eop  = 1'b1;
        mac.tx_err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign frame_end = (state_q == StXfer) && g_wren && g_eop && mac.tx_rdy;
  assign err_inc   = (state_q == StAbort) || ((state_q == StXfer) && mac.tx_uflow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      last_q    <= SelW'(N_REQ - 1);
      start_q   <= '0;
      grant_q   <= '0;
      wd_q      <= '0;
      gap_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      start_q <= '0;
      if (err_inc && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            sel_q   <= pick_sel;
            last_q  <= pick_sel;
            start_q <= pick_oh;
            grant_q <= pick_oh;
            state_q <= StStart;
          end
        end
        StStart: begin
          wd_q    <= '0;
          state_q <= StXfer;
        end
        StXfer: begin
          if (frame_end) begin
            grant_q <= '0;
            wd_q    <= '0;
            gap_q   <= '0;
            state_q <= StGap;
          end else if (wd_q == WdLast) begin
            wd_q    <= '0;
            state_q <= StAbort;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StAbort: begin
          grant_q <= '0;
          gap_q   <= '0;
          state_q <= StGap;
        end
        StGap: begin
          if (gap_q == GapLast) begin
            gap_q   <= '0;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start   = start_q;
  assign grant   = grant_q;
  assign busy    = (state_q != StIdle);
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_tx_sched.sv
// Directed self-checking bench for tx_sched: the bench plays the generators and the MAC.
module tb_tx_sched;
  import tx_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req, start, grant, s_tx_rdy;
  logic [2:0]  s_tx_sop, s_tx_eop, s_tx_wren, s_tx_err;
  logic [95:0] s_tx_data;
  logic [5:0]  s_tx_mod;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  tx_sched_if mac_if ();

  tx_sched #(
    .N_REQ      (3),
    .IFG_CYCLES (4),
    .TIMEOUT    (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .start     (start),
    .grant     (grant),
    .s_tx_data (s_tx_data),
    .s_tx_mod  (s_tx_mod),
    .s_tx_sop  (s_tx_sop),
    .s_tx_eop  (s_tx_eop),
    .s_tx_wren (s_tx_wren),
    .s_tx_err  (s_tx_err),
    .s_tx_rdy  (s_tx_rdy),
    .mac       (mac_if.master),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_idle(input int g);
    s_tx_data[g*32 +: 32] = 32'hDEAD_BEE0 | 32'(g);
    s_tx_mod[g*2 +: 2]    = 2'b11;
    s_tx_sop[g]  = 1'b0;
    s_tx_eop[g]  = 1'b0;
    s_tx_wren[g] = 1'b0;
    s_tx_err[g]  = 1'b0;
  endtask

  task automatic do_reset(input logic [2:0] r);
    rst_n = 1'b0;
    req   = r;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_bus", 64'({mac_if.tx_data, mac_if.tx_mod, mac_if.tx_sop, mac_if.tx_eop,
                              mac_if.tx_wren, mac_if.tx_err, start, grant, s_tx_rdy, busy,
                              err_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(output int g, output int lat);
    g   = -1;
    lat = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      tick();
      if (start != 3'b000) lat = n;
    end
    check_eq("start_seen", 64'(start != 3'b000), 64'd1);
    check_eq("start_onehot", 64'($countones(start)), 64'd1);
    for (int i = 0; i < 3; i++) if (start[i]) g = i;
  endtask

  // Called in the START cycle; drives generator g word by word, holding a word while rdy is low.
  task automatic send_frame(input int g, input int nw, input logic [31:0] rdy_pat,
                            input logic [31:0] uf_pat, input string tag);
    int w;
    logic [46:0] got, exp;
    logic [31:0] wd;
    logic [1:0]  md;
    logic [2:0]  gv;
    w  = 0;
    gv = 3'b001 << g;
    tick();
    for (int c = 0; c < 32 && w < nw; c++) begin
      wd = 32'hA000_0000 | (32'(g) << 16) | 32'(w);
      md = (w == nw - 1) ? 2'(g + 1) : 2'b00;
      s_tx_data[g*32 +: 32] = wd;
      s_tx_mod[g*2 +: 2]    = md;
      s_tx_sop[g]  = (w == 0);
      s_tx_eop[g]  = (w == nw - 1);
      s_tx_wren[g] = 1'b1;
      s_tx_err[g]  = 1'b0;
      mac_if.tx_rdy   = rdy_pat[c];
      mac_if.tx_uflow = uf_pat[c];
      #1;
      got = {mac_if.tx_data, mac_if.tx_mod, mac_if.tx_sop, mac_if.tx_eop, mac_if.tx_wren,
             mac_if.tx_err, s_tx_rdy, grant, start};
      exp = {wd, md, (w == 0), (w == nw - 1), 1'b1, 1'b0, (rdy_pat[c] ? gv : 3'b000), gv,
             3'b000};
      check_eq(tag, 64'(got), 64'(exp));
      if (rdy_pat[c]) w++;
      tick();
    end
    gen_idle(g);
    mac_if.tx_rdy   = 1'b1;
    mac_if.tx_uflow = 1'b0;
    #1;
    check_eq({tag, "_words"}, 64'(w), 64'(nw));
    check_eq({tag, "_gap"}, 64'({mac_if.tx_wren, grant, busy}), 64'(5'b0_000_1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL tb_timeout simulation did not finish");
    $fatal(1, "tb_timeout");
  end

  initial begin
    int g, lat, aborts;
    int rr_exp [4] = '{0, 1, 2, 0};
    bit done100;
    req = 3'b000;
    mac_if.tx_rdy   = 1'b1;
    mac_if.tx_uflow = 1'b0;
    for (int i = 0; i < 3; i++) gen_idle(i);

    // Single requester 0, 12-word frame, busy drops 5 cycles after EOP.
    do_reset(3'b001);
    wait_start(g, lat);
    check_eq("t1_sel", 64'(g), 64'd0);
    check_eq("t1_lat", 64'(lat), 64'd1);
    req = 3'b000;
    send_frame(0, 12, 32'hFFFF_FFFF, 32'h0, "t1_frame");
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_eq("t1_busy", 64'(busy), 64'(i < 5));
    end

    // All requesting from reset: grant order 0,1,2,0 with IFG between frames.
    do_reset(3'b111);
    for (int f = 0; f < 4; f++) begin
      wait_start(g, lat);
      check_eq("rr_grant", 64'(g), 64'(rr_exp[f]));
      if (f > 0) check_eq("rr_lat", 64'(lat), 64'd5);
      if (f == 3) req = 3'b000;
      send_frame(g, 3, 32'hFFFF_FFFF, 32'h0, "rr_frame");
    end

    // tx_rdy toggles mid-frame on requester 2.
    req = 3'b100;
    wait_start(g, lat);
    check_eq("t3_sel", 64'(g), 64'd2);
    check_eq("t3_lat", 64'(lat), 64'd5);
    req = 3'b000;
    send_frame(2, 4, 32'hFFFF_FFFD, 32'h0, "t3_frame");

    // Requester 1 never ends its frame: abort after 64 XFER cycles, then requester 2 served.
    req = 3'b010;
    wait_start(g, lat);
    check_eq("t4_sel", 64'(g), 64'd1);
    req = 3'b101;
    s_tx_data[63:32] = 32'h1234_5678;
    s_tx_mod[3:2]    = 2'b11;
    s_tx_sop[1]  = 1'b1;
    s_tx_wren[1] = 1'b1;
    tick();
    check_eq("t4_mux", 64'(mac_if.tx_data), 64'h1234_5678);
    for (int c = 0; c < 64; c++) begin
      check_eq("t4_xfer", 64'({mac_if.tx_eop, mac_if.tx_err, grant}), 64'(5'b00_010));
      tick();
    end
    check_eq("t4_abort", 64'({mac_if.tx_data, mac_if.tx_mod, mac_if.tx_sop, mac_if.tx_eop,
                              mac_if.tx_wren, mac_if.tx_err, s_tx_rdy, grant}),
             64'({32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 3'b010}));
    tick();
    check_eq("t4_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("t4_gap", 64'({mac_if.tx_wren, mac_if.tx_err, grant}), 64'd0);
    gen_idle(1);
    wait_start(g, lat);
    check_eq("t4_next_sel", 64'(g), 64'd2);
    check_eq("t4_next_lat", 64'(lat), 64'd5);
    req = 3'b000;
    send_frame(2, 2, 32'hFFFF_FFFF, 32'h0, "t4_next");

    // Asynchronous reset mid-XFER clears outputs at once; requester 0 wins afterwards.
    req = 3'b001;
    wait_start(g, lat);
    check_eq("t6_sel", 64'(g), 64'd0);
    req = 3'b000;
    s_tx_data[31:0] = 32'hCAFE_0001;
    s_tx_sop[0]  = 1'b1;
    s_tx_wren[0] = 1'b1;
    tick();
    check_eq("t6_pre", 64'(mac_if.tx_wren), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_bus", 64'({mac_if.tx_data, mac_if.tx_mod, mac_if.tx_sop, mac_if.tx_eop,
                                mac_if.tx_wren, mac_if.tx_err, start, grant, s_tx_rdy, busy,
                                err_cnt}), 64'd0);
    gen_idle(0);
    req = 3'b111;
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(g, lat);
    check_eq("t6_first", 64'(g), 64'd0);
    req = 3'b000;

    // Underflow on three XFER cycles counts three errors, frame completes.
    send_frame(0, 6, 32'hFFFF_FFFF, 32'h0000_0016, "t5_frame");
    check_eq("t5_err_cnt", 64'(err_cnt), 64'd3);

    // 300 back-to-back aborts saturate err_cnt at 255.
    s_tx_wren[0] = 1'b1;
    do_reset(3'b001);
    aborts  = 0;
    done100 = 1'b0;
    for (int c = 0; c < 30000 && aborts < 300; c++) begin
      tick();
      if (aborts == 100 && !done100) begin
        check_eq("sat_100", 64'(err_cnt), 64'd100);
        done100 = 1'b1;
      end
      if (mac_if.tx_err) aborts++;
    end
    tick();
    check_eq("sat_aborts", 64'(aborts), 64'd300);
    check_eq("sat_255", 64'(err_cnt), 64'd255);
    req = 3'b000;
    gen_idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_sched.md
# tx_sched

Round-robin scheduler that shares the single MAC transmit port (32-bit sop/eop/wren/mod interface with `tx_rdy` back-pressure) among `N_REQ` frame generators (ARP/ICMP reply sender, UDP sender, …). It starts one generator at a time with a one-cycle `en`-style pulse and muxes that generator's TX bus to the MAC until end-of-packet. It then enforces an inter-frame gap and a frame watchdog. It sits between the generators and the MAC TX FIFO.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters; index 0 = ARP/ICMP sender.
- `IFG_CYCLES`, 4: idle cycles inserted after every frame (1..15).
- `TIMEOUT`, 2048: max cycles in XFER before abort (≤ 4095).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level request per generator; held until its `start` is seen.
- `start`  out  N_REQ  one-cycle pulse, drives the generator's `en`.
- `grant`  out  N_REQ  one-hot, high from `start` until leaving XFER/ABORT.
- `s_tx_data`  in  32·N_REQ  generator data, slice i = bits [32i+31:32i].
- `s_tx_mod`  in  2·N_REQ  generator invalid-byte count.
- `s_tx_sop`, `s_tx_eop`, `s_tx_wren`, `s_tx_err`  in  N_REQ each.
- `s_tx_rdy`  out  N_REQ  `tx_rdy` routed to the granted generator only; 0 elsewhere.
- `tx_data` out 32, `tx_mod` out 2, `tx_sop`/`tx_eop`/`tx_wren`/`tx_err` out 1: MAC side.
- `tx_rdy`  in  1  MAC ready.
- `tx_uflow`  in  1  MAC underflow flag.
- `busy`  out  1  state ≠ IDLE.
- `err_cnt`  out  8  saturating count of aborts + underflow pulses during XFER.

## Operation
- States: IDLE, START, XFER, ABORT, GAP. Reset → IDLE, `last` pointer = N_REQ-1.
- IDLE:
  - If any `req`, pick the first set bit searching upward from `last+1` with wrap.
  - Register `sel` and set `last` = `sel`.
  - Assert `start[sel]` and `grant[sel]`, then go to START.
- START:
  - One cycle; `start` drops.
  - The generator needs ≥2 cycles after `en` to begin, so the mux is already active.
  - Go to XFER.
- XFER:
  - MAC outputs = granted slice (combinational mux on registered `sel`).
  - `s_tx_rdy[sel]` = `tx_rdy`.
  - Watchdog counts every cycle from 0.
  - Frame ends on an edge with `tx_wren & tx_eop & tx_rdy` → GAP.
  - If the watchdog reaches TIMEOUT-1 without end → ABORT.
- ABORT:
  - One cycle.
  - MAC sees `tx_wren=1`, `tx_eop=1`, `tx_err=1`, `tx_sop=0`, `tx_data=0`, `tx_mod=0`.
  - `s_tx_rdy` all 0; `err_cnt`++ (saturates at 255).
  - Go to GAP.
- GAP:
  - All MAC strobes 0, `grant` = 0.
  - Counter runs IFG_CYCLES cycles, then IDLE.
  - Requests are only sampled in IDLE.
- `req[sel]` is ignored while it is granted. A generator re-raising `req` after its frame waits its round-robin turn.
- `tx_uflow` high in XFER: `err_cnt`++ per cycle high (saturating). The frame is not aborted.
- Outside XFER/ABORT, all MAC outputs are 0.

## Timing
- Reset values: `start`=0, `grant`=0, `s_tx_rdy`=0, all `tx_*` outputs 0, `busy`=0, `err_cnt`=0, watchdog/gap counters 0.
- `rst_n` low mid-frame: everything returns to reset values immediately. No EOP is emitted, and the truncated frame is the MAC's responsibility.
- `req` seen in IDLE at edge k: `start`/`grant` high in cycle k+1; XFER from k+2.
- MAC path: zero-latency combinational from generator registers.
- End of frame, EOP accepted at edge e: GAP covers cycles e+1 … e+IFG_CYCLES; IDLE at e+IFG_CYCLES+1. Next `start` comes no earlier than e+IFG_CYCLES+2.
- `tx_rdy` low: the scheduler holds state; the watchdog still counts.
- Simultaneous requests on all inputs: grant order 0,1,2,0… from reset.

## Structure
- Shared package `tx_sched_pkg`: state enum, `TX_W=32`, `MOD_W=2`, default IFG/TIMEOUT constants.
- Sub-module `rr_pick`: combinational N-bit round-robin selector (`req`, `last` → `sel`, `valid`).
- Mux, FSM and counters live in `tx_sched`.

## Test plan
- Single requester 0 raises `req`: `start[0]` pulses one cycle. A 12-word ARP frame passes unchanged, sop on word 0 and eop on word 11. `busy` clears 5 cycles after EOP.
- `req`=3'b111 held from reset: grants in order 0,1,2,0. Each frame is separated by ≥4 idle MAC cycles.
- `tx_rdy` toggled 1-0-1 during a frame: `s_tx_rdy[sel]` follows. Others stay 0. No word is duplicated or dropped at the MAC.
- Generator never asserts eop, TIMEOUT=64: an ABORT cycle with wren/eop/err=1 appears at cycle 64 of XFER. `err_cnt`=1; the next requester is then served.
- `rst_n` pulsed low mid-XFER: all outputs 0 within the same cycle. After release, requester 0 wins first.
- `tx_uflow` high 3 cycles in XFER: `err_cnt`=3 and the frame completes normally. 300 aborts: `err_cnt` saturates at 255.
